// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-RAM boot controller.
// Holds the FSM encoding, the default NOP and the byte-to-word assembly widths.
package imem_pkg;

    localparam logic [1:0] ST_RUN_ENC       = 2'd0;
    localparam logic [1:0] ST_LOAD_LEN_ENC  = 2'd1;
    localparam logic [1:0] ST_LOAD_DATA_ENC = 2'd2;
    localparam logic [1:0] ST_WRITE_ENC     = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN       = ST_RUN_ENC,
        ST_LOAD_LEN  = ST_LOAD_LEN_ENC,
        ST_LOAD_DATA = ST_LOAD_DATA_ENC,
        ST_WRITE     = ST_WRITE_ENC
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_boot_ctrl_byte_packer.sv
// Little-endian 8-to-32 bit assembler shared by the length and data phases.
// word is combinational so the consumer can latch it on the word_valid cycle.
module byte_packer
    import imem_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    logic [BYTE_CNT_W-1:0] cnt_q;
    logic [BYTE_CNT_W-1:0] cnt_d;
    logic [WORD_W-1:0]     shift_q;
    logic [WORD_W-1:0]     shift_d;
    logic [WORD_W-1:0]     merged;

    always_comb begin
        // Newest byte enters at the top, so the first byte ends up in [7:0].
        merged     = {byte_data, shift_q[WORD_W-1:BYTE_W]};
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_valid = 1'b0;
        if (clear) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            shift_d    = merged;
            cnt_d      = cnt_q + 1'b1;
            word_valid = (cnt_q == {BYTE_CNT_W{1'b1}});
        end
    end

    assign word = merged;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Shares the instruction RAM between core fetch (RUN) and a UART boot loader
// that streams a 32-bit length followed by that many little-endian words.
module imem_boot_ctrl
    import imem_pkg::*;
#(
    parameter int          ADDR_WIDTH    = 12,
    parameter bit          BOOT_ON_RESET = 1'b1,
    parameter logic [31:0] NOP_INSTR     = NOP_INSTR_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  boot_req,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic [31:0]           fetch_addr,
    output logic [31:0]           instr,
    output logic                  core_reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata,
    output logic                  load_done,
    output logic                  load_err
);

    // One bit wider than the 32-bit counters so 2^32 depth still compares correctly.
    localparam logic [32:0] DEPTH = 33'd1 << ADDR_WIDTH;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] word_cnt_q;
    logic [31:0] word_cnt_d;
    logic [31:0] len_q;
    logic [31:0] len_d;
    logic [31:0] data_q;
    logic [31:0] data_d;
    logic        load_done_q;
    logic        load_done_d;
    logic        load_err_q;
    logic        load_err_d;

    logic        pk_clear;
    logic        pk_word_valid;
    logic [31:0] pk_word;
    logic        byte_acc;
    logic [31:0] word_cnt_inc;
    logic        unused_fetch_bits;

    assign byte_acc          = rx_valid && rx_ready;
    assign word_cnt_inc      = word_cnt_q + 32'd1;
    assign unused_fetch_bits = ^fetch_addr;

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_valid (byte_acc),
        .byte_data  (rx_data),
        .word       (pk_word),
        .word_valid (pk_word_valid)
    );

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        data_d      = data_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        pk_clear    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (boot_req) begin
                    state_d    = ST_LOAD_LEN;
                    word_cnt_d = '0;
                    len_d      = '0;
                    load_err_d = 1'b0;
                    pk_clear   = 1'b1;
                end
            end
            ST_LOAD_LEN: begin
                if (pk_word_valid) begin
                    len_d = pk_word;
                    if ({1'b0, pk_word} > DEPTH) begin
                        load_err_d = 1'b1;
                    end
                    if (pk_word == 32'd0) begin
                        state_d     = ST_RUN;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD_DATA;
                    end
                end
            end
            ST_LOAD_DATA: begin
                if (pk_word_valid) begin
                    data_d  = pk_word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                word_cnt_d = word_cnt_inc;
                if (word_cnt_inc == len_q) begin
                    state_d     = ST_RUN;
                    load_done_d = 1'b1;
                end else begin
                    state_d = ST_LOAD_DATA;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        mem_addr   = word_cnt_q[ADDR_WIDTH-1:0];
        mem_wdata  = data_q;
        mem_we     = 1'b0;
        rx_ready   = 1'b0;
        instr      = NOP_INSTR;
        core_reset = 1'b1;
        case (state_q)
            ST_RUN: begin
                mem_addr   = fetch_addr[ADDR_WIDTH+1:2];
                instr      = mem_rdata;
                core_reset = 1'b0;
            end
            ST_LOAD_LEN, ST_LOAD_DATA: rx_ready = 1'b1;
            // Overflow words are still drained from the FIFO, just not stored.
            ST_WRITE: mem_we = ({1'b0, word_cnt_q} < DEPTH);
            default: ;
        endcase
        if (reset) begin
            mem_we     = 1'b0;
            rx_ready   = 1'b0;
            core_reset = 1'b1;
        end
    end

    assign load_done = load_done_q;
    assign load_err  = load_err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= BOOT_ON_RESET ? ST_LOAD_LEN : ST_RUN;
            word_cnt_q  <= '0;
            len_q       <= '0;
            data_q      <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            data_q      <= data_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

endmodule
